// File: rtl/gray_updown_counter.sv
// Up/down binary counter with a registered Gray-coded copy, wrap pulse and optional saturation.
// Define GRAY_STEP_CHECK_EN to build in the sticky Gray single-bit-step checker driving err.
module gray_updown_counter #(
    parameter int DATA_WIDTH = 4,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gray_en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_val,
    output logic [DATA_WIDTH-1:0] binary_out,
    output logic [DATA_WIDTH-1:0] gray_out,
    output logic                  wrap,
    output logic                  err
);

    localparam logic [DATA_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [DATA_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [DATA_WIDTH-1:0] CNT_ONE  = DATA_WIDTH'(1);

    function automatic logic [DATA_WIDTH-1:0] bin2gray(input logic [DATA_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [DATA_WIDTH-1:0] binary_q, binary_d;
    logic [DATA_WIDTH-1:0] gray_q,   gray_d;
    logic                  wrap_q,   wrap_d;
    logic                  step_en;

    assign step_en = gray_en & ~load;

    // Next count: load beats counting; limits either wrap (pulsing wrap) or hold.
    always_comb begin
        binary_d = binary_q;
        wrap_d   = 1'b0;
        if (load) begin
            binary_d = load_val;
        end else if (gray_en) begin
            if (up_dn) begin
                if (binary_q == CNT_MAX) begin
                    if (SATURATE == 0) begin
                        binary_d = CNT_ZERO;
                        wrap_d   = 1'b1;
                    end
                end else begin
                    binary_d = binary_q + CNT_ONE;
                end
            end else begin
                if (binary_q == CNT_ZERO) begin
                    if (SATURATE == 0) begin
                        binary_d = CNT_MAX;
                        wrap_d   = 1'b1;
                    end
                end else begin
                    binary_d = binary_q - CNT_ONE;
                end
            end
        end
        gray_d = bin2gray(binary_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            binary_q <= CNT_ZERO;
            gray_q   <= CNT_ZERO;
            wrap_q   <= 1'b0;
        end else begin
            binary_q <= binary_d;
            gray_q   <= gray_d;
            wrap_q   <= wrap_d;
        end
    end

    assign binary_out = binary_q;
    assign gray_out   = gray_q;
    assign wrap       = wrap_q;

`ifdef GRAY_STEP_CHECK_EN
    function automatic int unsigned popcount(input logic [DATA_WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    logic [DATA_WIDTH-1:0] prev_gray_q;
    logic                  step_q;
    logic                  err_q, err_d;

    // The checker watches the output port itself, one cycle after each count step;
    // a zero-bit change (saturated hold) is legal, more than one bit is not.
    always_comb begin
        err_d = err_q;
        if (step_q && (popcount(gray_out ^ prev_gray_q) > 1)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray_q <= CNT_ZERO;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            prev_gray_q <= gray_out;
            step_q      <= step_en;
            err_q       <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_step;
    assign unused_step = step_en;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed bench for gray_updown_counter: wrap-mode and saturate-mode instances share stimulus.
module tb_gray_updown_counter;

    logic       clk;
    logic       rst;
    logic       gray_en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] bin0, gray0, bin1, gray1;
    logic       wrap0, err0, wrap1, err1;

    int n_vec;
    int n_err;

    gray_updown_counter #(.DATA_WIDTH(4), .SATURATE(0)) dut0 (
        .clk(clk), .rst(rst), .gray_en(gray_en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .binary_out(bin0), .gray_out(gray0), .wrap(wrap0), .err(err0)
    );

    gray_updown_counter #(.DATA_WIDTH(4), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .gray_en(gray_en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .binary_out(bin1), .gray_out(gray1), .wrap(wrap1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one set of inputs across a rising edge, then sample 1 ns later.
    task automatic cyc(input logic r, input logic ld, input logic [3:0] lv,
                       input logic en, input logic up);
        rst      = r;
        load     = ld;
        load_val = lv;
        gray_en  = en;
        up_dn    = up;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_b;
    logic [3:0] exp_g;
    logic [3:0] seq_b [3];
    logic [3:0] seq_g [3];

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
        gray_en  = 1'b0;
        up_dn    = 1'b0;
        @(negedge clk);

        // Reset, with load and enable active to show reset dominates.
        cyc(1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
        check("rst_bin0", bin0, 0);
        check("rst_gray0", gray0, 0);
        check("rst_wrap0", wrap0, 0);
        check("rst_err0", err0, 0);
        check("rst_bin1", bin1, 0);
        check("rst_err1", err1, 0);

        // Count up 20 cycles: 1..15, 0 (wrap), 1..4.
        exp_b = 4'd0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
            exp_b = exp_b + 4'd1;
            exp_g = {exp_b[3], exp_b[3] ^ exp_b[2], exp_b[2] ^ exp_b[1], exp_b[1] ^ exp_b[0]};
            check($sformatf("up_bin_%0d", i), bin0, exp_b);
            check($sformatf("up_gray_%0d", i), gray0, exp_g);
            check($sformatf("up_wrap_%0d", i), wrap0, (exp_b == 4'd0) ? 1 : 0);
        end

        // Load 9 then count down three.
        cyc(1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
        check("ld9_bin", bin0, 9);
        check("ld9_gray", gray0, 4'b1101);
        check("ld9_wrap", wrap0, 0);
        seq_b[0] = 4'd8; seq_g[0] = 4'b1100;
        seq_b[1] = 4'd7; seq_g[1] = 4'b0100;
        seq_b[2] = 4'd6; seq_g[2] = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            check($sformatf("dn_bin_%0d", i), bin0, seq_b[i]);
            check($sformatf("dn_gray_%0d", i), gray0, seq_g[i]);
        end

        // Underflow wrap from 0, then hold drops the pulse.
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("uf_bin", bin0, 15);
        check("uf_gray", gray0, 4'b1000);
        check("uf_wrap", wrap0, 1);
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("hold_bin", bin0, 15);
        check("hold_wrap", wrap0, 0);

        // Load 14 and count up: saturating instance sticks at 15, wrapping one rolls over.
        cyc(1'b0, 1'b1, 4'd14, 1'b0, 1'b1);
        seq_b[0] = 4'd15; seq_b[1] = 4'd0; seq_b[2] = 4'd1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
            check($sformatf("sat_up_bin_%0d", i), bin1, 15);
            check($sformatf("sat_up_gray_%0d", i), gray1, 4'b1000);
            check($sformatf("sat_up_wrap_%0d", i), wrap1, 0);
            check($sformatf("wr_up_bin_%0d", i), bin0, seq_b[i]);
        end

        // Load 1 and count down: saturating instance sticks at 0.
        cyc(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        seq_b[0] = 4'd0; seq_b[1] = 4'd15; seq_b[2] = 4'd14;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            check($sformatf("sat_dn_bin_%0d", i), bin1, 0);
            check($sformatf("sat_dn_wrap_%0d", i), wrap1, 0);
            check($sformatf("wr_dn_bin_%0d", i), bin0, seq_b[i]);
            check($sformatf("wr_dn_wrap_%0d", i), wrap0, (i == 1) ? 1 : 0);
        end

        // Load wins over enable; reset wins over load.
        cyc(1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
        check("ldpri_bin", bin0, 5);
        check("ldpri_gray", gray0, 4'b0111);
        check("ldpri_wrap", wrap0, 0);
        cyc(1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
        check("rstpri_bin", bin0, 0);
        check("rstpri_gray", gray0, 0);

        // Reset mid-count aborts the step; counting restarts from 0.
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check("pre_rst_bin", bin0, 2);
        cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
        check("mid_rst_bin", bin0, 0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check("post_rst_bin", bin0, 1);

        // Direction reversal on back-to-back enabled cycles.
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check("rev_up_bin", bin0, 2);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("rev_dn_bin", bin0, 1);
        check("rev_dn_gray", gray0, 4'b0001);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        check("rev_up2_bin", bin0, 2);

`ifdef GRAY_STEP_CHECK_EN
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        check("rand_err0", err0, 0);
        check("rand_err1", err1, 0);
        cyc(1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        force dut0.gray_out = ~gray0;
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        release dut0.gray_out;
        check("force_err", err0, 1);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        check("sticky_err", err0, 1);
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        check("clr_err", err0, 0);
`else
        check("err0_tied", err0, 0);
        check("err1_tied", err1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gray_updown_counter.md
GRAY_UPDOWN_COUNTER -- requirements
Module: gray_updown_counter

Interface
REQ-001: Parameter DATA_WIDTH, default 4, counter width in bits; legal range 2..32.
REQ-002: Parameter SATURATE, default 0, 0 = wrap-around mode, 1 = saturate-at-limit mode.
REQ-003: Port clk  input  1  single clock; all state updates on rising edge.
REQ-004: Port rst  input  1  reset, synchronous, active-high.
REQ-005: Port gray_en  input  1  count enable, sampled on rising clk.
REQ-006: Port up_dn  input  1  direction; 1 = increment, 0 = decrement.
REQ-007: Port load  input  1  synchronous load strobe.
REQ-008: Port load_val  input  DATA_WIDTH  binary value to load.
REQ-009: Port binary_out  output  DATA_WIDTH  registered binary count.
REQ-010: Port gray_out  output  DATA_WIDTH  registered Gray encoding of binary_out.
REQ-011: Port wrap  output  1  one-cycle pulse on wrap-around event.
REQ-012: Port err  output  1  sticky Gray single-bit-step violation flag.

Function
REQ-013: Priority per cycle SHALL be rst > load > gray_en > hold.
REQ-014: load=1 SHALL set binary_out=load_val and gray_out=load_val^(load_val>>1) on the next edge, ignoring gray_en/up_dn; wrap=0 that cycle.
REQ-015: gray_en=1, load=0 SHALL step binary_out by +1 (up_dn=1) or -1 (up_dn=0), one-clock latency.
REQ-016: gray_en=0, load=0 SHALL hold binary_out and gray_out.
REQ-017: gray_out SHALL equal binary_out^(binary_out>>1) in every cycle; both update on the same edge, no skew.
REQ-018: SATURATE=0: up from 2^DATA_WIDTH-1 SHALL go to 0; down from 0 SHALL go to 2^DATA_WIDTH-1.
REQ-019: SATURATE=0: wrap SHALL be 1 for exactly the cycle binary_out holds the wrapped value, else 0.
REQ-020: SATURATE=1: up at 2^DATA_WIDTH-1 and down at 0 SHALL hold value; wrap SHALL stay 0.
REQ-021: Direction change on consecutive enabled cycles SHALL take effect immediately (no dead cycle).
REQ-022: All arithmetic modulo 2^DATA_WIDTH; no internal width extension visible at ports.

Reset
REQ-023: rst=1 at a rising edge SHALL set binary_out=0, gray_out=0, wrap=0, err=0, regardless of load/gray_en.
REQ-024: rst asserted mid-count SHALL abort the step; first count after release SHALL start from 0.
REQ-025: Outputs before the first reset edge are undefined; the bench SHALL not check them.

Configuration
REQ-026: Macro GRAY_STEP_CHECK_EN, when defined, SHALL compile in a checker that stores previous gray_out and sets err=1 (sticky until rst) if a count step (not load, not reset) changes gray_out by other than exactly one bit.
REQ-027: Saturated holds (zero-bit change) SHALL not set err.
REQ-028: Without GRAY_STEP_CHECK_EN, err SHALL be tied to 0 and no checker logic is synthesised; port list unchanged.

Verification (DATA_WIDTH=4)
REQ-029: rst=1 two cycles, then gray_en=1, up_dn=1 for 20 cycles -> binary_out 0..15,0..3; gray_out matches encoding each cycle; wrap=1 only when binary_out returns to 0.
REQ-030: load=1, load_val=9 -> binary_out=9, gray_out=4'b1101; then up_dn=0 three cycles -> 8,7,6 (gray 1100,0100,0101).
REQ-031: SATURATE=0, load 0, up_dn=0, gray_en=1 -> binary_out=15, gray_out=4'b1000, wrap=1 one cycle.
REQ-032: SATURATE=1, load 14, count up 3 cycles -> 15,15,15, wrap=0; load 1, count down 3 -> 0,0,0, wrap=0.
REQ-033: load=1 and gray_en=1 same cycle with load_val=5 -> binary_out=5 (load wins); rst=1 with load=1 -> binary_out=0.
REQ-034: GRAY_STEP_CHECK_EN defined, 100 random enable/direction/load cycles -> err stays 0; forced gray_out multi-bit corruption via force -> err=1 until rst.
